// File: rtl/polinomio_horner.sv
// Unsigned polynomial evaluator (degree GRAU, width W) using Horner's rule, one multiply-add per clock.
// Control FSM with start/acknowledge handshake, busy flag and sticky overflow.
module polinomio_horner #(
    parameter int W    = 16,
    parameter int GRAU = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic                  pronto,
    input  logic [W-1:0]          X,
    input  logic [(GRAU+1)*W-1:0] COEF,
    output logic [W-1:0]          Resultado,
    output logic                  LED,
    output logic                  ocupado,
    output logic                  estouro
);
    localparam int CW = (GRAU > 0) ? $clog2(GRAU + 1) : 1;

    typedef enum logic [1:0] {OCIOSO = 2'd0, CALCULA = 2'd1, FIM = 2'd2} estado_t;

    estado_t              estado_q;
    logic [W-1:0]         x_q, acc_q, res_q;
    logic [GRAU:0][W-1:0] coef_q;
    logic [CW-1:0]        cnt_q;
    logic                 led_q, ocu_q, est_q;

    logic [CW-1:0]        idx_d;
    logic [W-1:0]         addend_d;
    logic [2*W-1:0]       mac_d;
    logic                 ovf_d;

    // Full-width multiply-add so overflow can be seen in the upper half.
    always_comb begin
        idx_d    = cnt_q - CW'(1);
        addend_d = '0;
        for (int k = 0; k <= GRAU; k++) begin
            if (CW'(k) == idx_d) addend_d = coef_q[k];
        end
        mac_d = ({{W{1'b0}}, acc_q} * {{W{1'b0}}, x_q}) + {{W{1'b0}}, addend_d};
        ovf_d = |mac_d[2*W-1:W];
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            estado_q <= OCIOSO;
            x_q      <= '0;
            coef_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            led_q    <= 1'b0;
            ocu_q    <= 1'b0;
            est_q    <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        x_q    <= X;
                        coef_q <= COEF;
                        acc_q  <= COEF[GRAU*W +: W];
                        cnt_q  <= CW'(GRAU);
                        est_q  <= 1'b0;
                        if (GRAU == 0) begin
                            // A constant polynomial is its own result.
                            res_q    <= COEF[GRAU*W +: W];
                            led_q    <= 1'b1;
                            estado_q <= FIM;
                        end else begin
                            ocu_q    <= 1'b1;
                            estado_q <= CALCULA;
                        end
                    end
                end
                CALCULA: begin
                    acc_q <= mac_d[W-1:0];
                    cnt_q <= idx_d;
                    if (ovf_d) est_q <= 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_q    <= mac_d[W-1:0];
                        led_q    <= 1'b1;
                        ocu_q    <= 1'b0;
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    if (pronto) begin
                        led_q    <= 1'b0;
                        estado_q <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign Resultado = res_q;
    assign LED       = led_q;
    assign ocupado   = ocu_q;
    assign estouro   = est_q;
endmodule

// File: tb/tb_polinomio_horner.sv
// Bench for polinomio_horner: three configurations (16/2, 8/3, 16/0) against a power-sum reference model.
module tb_polinomio_horner;
    logic        ck, rst;
    logic [2:0]  ini, prn;
    logic [15:0] x_a, x_c;
    logic [7:0]  x_b;
    logic [47:0] coef_a;
    logic [31:0] coef_b;
    logic [15:0] coef_c;
    wire  [15:0] res_a, res_c;
    wire  [7:0]  res_b;
    wire  [2:0]  led, ocu, est;
    int          n_cmp, n_err;

    polinomio_horner #(.W(16), .GRAU(2)) u_a (
        .ck(ck), .rst(rst), .inicio(ini[0]), .pronto(prn[0]), .X(x_a), .COEF(coef_a),
        .Resultado(res_a), .LED(led[0]), .ocupado(ocu[0]), .estouro(est[0]));
    polinomio_horner #(.W(8), .GRAU(3)) u_b (
        .ck(ck), .rst(rst), .inicio(ini[1]), .pronto(prn[1]), .X(x_b), .COEF(coef_b),
        .Resultado(res_b), .LED(led[1]), .ocupado(ocu[1]), .estouro(est[1]));
    polinomio_horner #(.W(16), .GRAU(0)) u_c (
        .ck(ck), .rst(rst), .inicio(ini[2]), .pronto(prn[2]), .X(x_c), .COEF(coef_c),
        .Resultado(res_c), .LED(led[2]), .ocupado(ocu[2]), .estouro(est[2]));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int deg_of(input int d);
        case (d)
            0: return 2;
            1: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int w_of(input int d);
        return (d == 1) ? 8 : 16;
    endfunction

    function automatic longint get_res(input int d);
        case (d)
            0: return longint'(res_a);
            1: return longint'(res_b);
            default: return longint'(res_c);
        endcase
    endfunction

    task automatic set_in(input int d, input longint x, input longint c[4]);
        case (d)
            0: begin x_a = 16'(x); coef_a = {16'(c[2]), 16'(c[1]), 16'(c[0])}; end
            1: begin x_b = 8'(x); coef_b = {8'(c[3]), 8'(c[2]), 8'(c[1]), 8'(c[0])}; end
            default: begin x_c = 16'(x); coef_c = 16'(c[0]); end
        endcase
    endtask

    // Value as sum of c[k]*x^k mod 2^W; overflow from the wide intermediate of each multiply-add step.
    function automatic void ref_eval(input int d, input longint x, input longint c[4],
                                     output longint res, output bit ovf);
        int     w = w_of(d);
        int     g = deg_of(d);
        longint m = (longint'(1) << w) - 1;
        longint p = 1;
        longint a;
        res = 0;
        for (int k = 0; k <= g; k++) begin
            res = (res + (c[k] & m) * p) & m;
            p   = (p * (x & m)) & m;
        end
        ovf = 1'b0;
        a   = c[g] & m;
        for (int k = g - 1; k >= 0; k--) begin
            a = a * (x & m) + (c[k] & m);
            if ((a >> w) != 0) ovf = 1'b1;
            a = a & m;
        end
    endfunction

    task automatic ack_fim(input int d, input longint er, input bit eo);
        @(posedge ck); #1;
        chk("led_hold", led[d], 1);
        prn[d] = 1'b1;
        @(posedge ck); #1;
        prn[d] = 1'b0;
        chk("led_drop", led[d], 0);
        chk("res_hold", get_res(d), er);
        chk("est_hold", est[d], eo);
        @(posedge ck); #1;
        chk("idle_ocu", ocu[d], 0);
        chk("idle_led", led[d], 0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run(input int d, input longint x, input longint c[4],
                       input bit ack, input bit poke, output longint got);
        longint er;
        bit     eo;
        int     edges, ocnt, g;
        longint s[4];
        g = deg_of(d);
        ref_eval(d, x, c, er, eo);
        set_in(d, x, c);
        ini[d] = 1'b1;
        @(posedge ck); #1;
        ini[d] = 1'b0;
        edges  = 1;
        ocnt   = 0;
        chk("est_clr", est[d], 0);
        for (int k = 0; k < 4; k++) s[k] = longint'($urandom);
        set_in(d, longint'($urandom), s);
        while (!led[d] && edges <= g + 4) begin
            if (ocu[d]) ocnt++;
            ini[d] = poke && (edges == 2);
            @(posedge ck); #1;
            edges++;
        end
        ini[d] = 1'b0;
        chk("latency", edges, g + 1);
        chk("ocupado_cyc", ocnt, g);
        chk("ocu_fim", ocu[d], 0);
        chk("res", get_res(d), er);
        chk("estouro", est[d], eo);
        got = get_res(d);
        if (ack) ack_fim(d, er, eo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        longint c[4];
        longint got, x, m;
        int     e;
        n_cmp = 0; n_err = 0;
        rst = 1'b0; ini = '0; prn = '0;
        x_a = '0; x_b = '0; x_c = '0; coef_a = '0; coef_b = '0; coef_c = '0;
        #3;
        for (int d = 0; d < 3; d++) begin
            chk("rst_res", get_res(d), 0);
            chk("rst_led", led[d], 0);
            chk("rst_ocu", ocu[d], 0);
            chk("rst_est", est[d], 0);
        end
        #20 rst = 1'b1;
        @(posedge ck); #1;

        c = '{4902, 333, 38, 0};
        run(0, 23, c, 1'b1, 1'b0, got);
        chk("tp1_res", got, 32663);

        c = '{1, 2, 0, 0};
        run(0, 65535, c, 1'b1, 1'b0, got);
        chk("tp2_res", got, 65535);
        chk("tp2_ovf", est[0], 1);
        c = '{4902, 333, 38, 0};
        run(0, 23, c, 1'b1, 1'b0, got);
        chk("tp2_clean", est[0], 0);

        c = '{4, 3, 2, 1};
        run(1, 3, c, 1'b1, 1'b1, got);
        chk("tp3_res", got, 58);

        c = '{4902, 0, 0, 0};
        run(2, 7, c, 1'b1, 1'b0, got);
        chk("tp4_res", got, 4902);

        // inicio together with pronto in FIM: back to idle first, then restart from held inicio
        c = '{4902, 333, 38, 0};
        run(0, 23, c, 1'b0, 1'b0, got);
        c = '{1, 1, 1, 0};
        set_in(0, 5, c);
        ini[0] = 1'b1; prn[0] = 1'b1;
        @(posedge ck); #1;
        prn[0] = 1'b0;
        chk("sim_led", led[0], 0);
        chk("sim_ocu", ocu[0], 0);
        @(posedge ck); #1;
        ini[0] = 1'b0;
        chk("sim_start", ocu[0], 1);
        e = 0;
        while (!led[0] && e < 10) begin
            @(posedge ck); #1;
            e++;
        end
        chk("sim_lat", e, 2);
        chk("sim_res", res_a, 31);
        ack_fim(0, 31, 1'b0);

        // asynchronous reset during the second CALCULA cycle
        c = '{4902, 333, 38, 0};
        set_in(0, 23, c);
        ini[0] = 1'b1;
        @(posedge ck); #1;
        ini[0] = 1'b0;
        @(posedge ck); #2;
        rst = 1'b0;
        #1;
        chk("arst_res", res_a, 0);
        chk("arst_led", led[0], 0);
        chk("arst_ocu", ocu[0], 0);
        chk("arst_est", est[0], 0);
        @(posedge ck); #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge ck); #1;
            chk("post_rst_ocu", ocu[0], 0);
            chk("post_rst_led", led[0], 0);
            chk("post_rst_res", res_a, 0);
        end
        run(0, 23, c, 1'b1, 1'b0, got);
        chk("fresh_res", got, 32663);

        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 3; d++) begin
                m = (longint'(1) << w_of(d)) - 1;
                x = (i % 4 == 0) ? m : (longint'($urandom) & m);
                for (int k = 0; k < 4; k++)
                    c[k] = (i % 4 == 1) ? m : (longint'($urandom) & m);
                run(d, x, c, 1'b1, 1'b0, got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
